// File: rtl/ch_config_spi_rx.sv
// SPI configuration receiver for the per-channel register blocks.
// Frames are 24 bits (header, address, data), mode 0, MSB first. Valid write
// frames turn into a one-cycle write strobe per selected channel. Read frames
// return both channels' load-protect state on MISO during bits 17..24.
module ch_config_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 24
) (
    input  logic       CLK_LOW,
    input  logic       RST,
    input  logic       SPI_SCLK,
    input  logic       SPI_CS_N,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    input  logic       CH1_PROTECT_STATE,
    input  logic       CH2_PROTECT_STATE,
    output logic       CH1_CONFIG_WE,
    output logic       CH2_CONFIG_WE,
    output logic [7:0] CONFIG_ADDR,
    output logic [7:0] CONFIG_DATA,
    output logic       FRAME_ERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    // Bit-count milestones: last data bit, header complete, first shifted readback bit.
    localparam logic [4:0] CNT_LAST     = 5'(FRAME_BITS - 1);
    localparam logic [4:0] CNT_STATUS   = 5'd15;
    localparam logic [4:0] CNT_MISO_SHF = 5'd17;

    // Frame length is hard-wired into the field layout; reject anything else at elaboration.
    if ((FRAME_BITS != 24) || (SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_param_check
        $error("ch_config_spi_rx: FRAME_BITS must be 24 and SYNC_STAGES 2..4");
    end

    // ------------------------------------------------------------------
    // Input synchronizers: index 0 = SCLK, 1 = CS_N, 2 = MOSI. All three use
    // the same depth so MOSI stays aligned with the SCLK edge that samples it.
    // CS_N resets to 0 so a frame already in progress at reset is ignored
    // until CS_N goes high and falls again.
    // ------------------------------------------------------------------
    logic [2:0]             async_in;
    logic [SYNC_STAGES-1:0] sync_reg [3];

    assign async_in = {SPI_MOSI, SPI_CS_N, SPI_SCLK};

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_sync
        // Shift the asynchronous input through its synchronizer chain.
        always_ff @(posedge CLK_LOW or posedge RST) begin
            if (RST) begin
                sync_reg[gi] <= '0;
            end else begin
                sync_reg[gi] <= {sync_reg[gi][SYNC_STAGES-2:0], async_in[gi]};
            end
        end
    end

    logic sclk_s;
    logic cs_s;
    logic mosi_s;

    assign sclk_s = sync_reg[0][SYNC_STAGES-1];
    assign cs_s   = sync_reg[1][SYNC_STAGES-1];
    assign mosi_s = sync_reg[2][SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Datapath / FSM registers
    // ------------------------------------------------------------------
    logic [1:0]            state_reg;
    logic [4:0]            bit_cnt_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [7:0]            addr_reg;
    logic [7:0]            data_reg;
    logic                  we1_reg;
    logic                  we2_reg;
    logic                  ferr_reg;
    logic                  drain_err_reg;
    logic [7:0]            miso_sr_reg;
    logic                  sclk_prev_reg;
    logic                  cs_prev_reg;

    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  cs_fall;
    logic [FRAME_BITS-1:0] frame_next;
    logic [7:0]            hdr_next;
    logic                  hdr_next_write_ok;
    logic [7:0]            hdr;

    assign sclk_rise  = sclk_s & ~sclk_prev_reg;
    assign sclk_fall  = ~sclk_s & sclk_prev_reg;
    assign cs_fall    = ~cs_s & cs_prev_reg;
    assign frame_next = {shift_reg[FRAME_BITS-2:0], mosi_s};

    // Header as it will look once the bit being sampled now is shifted in;
    // used to load ADDR/DATA on the last bit so they settle before the strobe.
    assign hdr_next          = frame_next[FRAME_BITS-1 -: 8];
    assign hdr_next_write_ok = hdr_next[7] && (hdr_next[6:2] == 5'd0) && (hdr_next[1:0] != 2'd0);

    // Header of the completed frame, evaluated in COMMIT.
    assign hdr = shift_reg[FRAME_BITS-1 -: 8];

    // Frame FSM: shift in bits, commit the frame, flag errors, drive readback.
    always_ff @(posedge CLK_LOW or posedge RST) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            addr_reg      <= '0;
            data_reg      <= '0;
            we1_reg       <= 1'b0;
            we2_reg       <= 1'b0;
            ferr_reg      <= 1'b0;
            drain_err_reg <= 1'b0;
            miso_sr_reg   <= '0;
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b0;
        end else begin
            sclk_prev_reg <= sclk_s;
            cs_prev_reg   <= cs_s;
            we1_reg       <= 1'b0;
            we2_reg       <= 1'b0;
            ferr_reg      <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    miso_sr_reg <= '0;
                    if (cs_fall) begin
                        state_reg     <= ST_SHIFT;
                        bit_cnt_reg   <= '0;
                        drain_err_reg <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (cs_s) begin
                        // CS_N released early: partial frame is an error, empty one is not.
                        state_reg   <= ST_IDLE;
                        miso_sr_reg <= '0;
                        if (bit_cnt_reg != 5'd0) begin
                            ferr_reg <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shift_reg   <= frame_next;
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        // Bit 16 arriving: header is complete, latch status for a read.
                        if ((bit_cnt_reg == CNT_STATUS) && !shift_reg[CNT_STATUS - 5'd1]) begin
                            miso_sr_reg <= {6'b0, CH2_PROTECT_STATE, CH1_PROTECT_STATE};
                        end
                        if (bit_cnt_reg == CNT_LAST) begin
                            state_reg <= ST_COMMIT;
                            if (hdr_next_write_ok) begin
                                addr_reg <= frame_next[15:8];
                                data_reg <= frame_next[7:0];
                            end
                        end
                    end else if (sclk_fall && (bit_cnt_reg >= CNT_MISO_SHF)) begin
                        // The fall after bit 16 keeps the MSB so the MCU sees it on bit 17.
                        miso_sr_reg <= {miso_sr_reg[6:0], 1'b0};
                    end
                end

                ST_COMMIT: begin
                    state_reg   <= ST_DRAIN;
                    miso_sr_reg <= '0;
                    if (hdr[6:2] != 5'd0) begin
                        ferr_reg <= 1'b1;
                    end else if (hdr[7]) begin
                        if (hdr[1:0] == 2'd0) begin
                            ferr_reg <= 1'b1;
                        end else begin
                            we1_reg <= hdr[0];
                            we2_reg <= hdr[1];
                        end
                    end
                end

                default: begin // ST_DRAIN
                    miso_sr_reg <= '0;
                    if (cs_s) begin
                        state_reg <= ST_IDLE;
                    end else if (sclk_rise && !drain_err_reg) begin
                        // Overrun: report once per frame no matter how many extra clocks.
                        ferr_reg      <= 1'b1;
                        drain_err_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign SPI_MISO      = miso_sr_reg[7];
    assign CH1_CONFIG_WE = we1_reg;
    assign CH2_CONFIG_WE = we2_reg;
    assign CONFIG_ADDR   = addr_reg;
    assign CONFIG_DATA   = data_reg;
    assign FRAME_ERR     = ferr_reg;

endmodule
